// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the pipelined MIPS core.
// Accepts one instruction per cycle from execute. Non-memory and misaligned
// instructions retire one cycle later. Aligned loads/stores go through a
// single-outstanding request/ready bus with big-endian lane steering, load
// extension and a bus-timeout watchdog.
module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    // execute stage
    input  logic        ex_valid,
    input  logic        ex_load,
    input  logic        ex_store,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_ea,
    input  logic [31:0] ex_dm_in,
    input  logic [31:0] ex_alu_res,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wb_en,
    // data-memory bus
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    // pipeline control and writeback
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        adel,
    output logic        ades,
    output logic        buserr
);

    // Wide enough for the largest legal TIMEOUT_CYCLES (1023).
    localparam int unsigned CNT_W = 10;

    // The counter holds the number of REQ cycles already completed, so the
    // last permitted cycle is the one where it equals TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        IDLE,
        REQ
    } state_t;

    state_t           state;
    logic [1:0]       req_size;
    logic             req_unsigned;
    logic [4:0]       req_rd;
    logic [1:0]       req_k;
    logic [CNT_W-1:0] timeout_cnt;

    // ------------------------------------------------------------------
    // Lane helpers (big-endian: byte offset 0 lives in bits [31:24]).
    // Size 2'b11 falls into the word case everywhere.
    // ------------------------------------------------------------------

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] k);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = k[0];
            default: r = (k != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] k);
        logic [3:0] r;
        case (size)
            SZ_BYTE: r = 4'b1000 >> k;
            SZ_HALF: r = k[1] ? 4'b0011 : 4'b1100;
            default: r = 4'b1111;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{d[7:0]}};
            SZ_HALF: r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [1:0]  size,
        input logic [1:0]  k,
        input logic        uns,
        input logic [31:0] rdata
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (k)
            2'd0:    b = rdata[31:24];
            2'd1:    b = rdata[23:16];
            2'd2:    b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = k[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            SZ_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Request and stall are pure decodes of the state register, so neither
    // has a combinational path from mem_ready.
    assign mem_req = (state == REQ);
    assign stall   = (state == REQ);

    // Stage FSM: accept in IDLE, run the bus transaction in REQ, retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_en        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            adel         <= 1'b0;
            ades         <= 1'b0;
            buserr       <= 1'b0;
            req_size     <= '0;
            req_unsigned <= 1'b0;
            req_rd       <= '0;
            req_k        <= '0;
            timeout_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this
            // block sees the value from before the clock edge; the pulse
            // defaults below are simply overridden by later assignments.
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            adel     <= 1'b0;
            ades     <= 1'b0;
            buserr   <= 1'b0;

            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (!(ex_load || ex_store)) begin
                            wb_valid <= 1'b1;
                            wb_en    <= ex_wb_en;
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_alu_res;
                        end else if (is_misaligned(ex_size, ex_ea[1:0])) begin
                            // No bus cycle; retire as an address exception.
                            // A set store bit wins over a set load bit.
                            wb_valid <= 1'b1;
                            wb_rd    <= ex_rd;
                            adel     <= !ex_store;
                            ades     <= ex_store;
                        end else begin
                            state        <= REQ;
                            mem_we       <= ex_store;
                            mem_addr     <= {ex_ea[31:2], 2'b00};
                            mem_be       <= lane_be(ex_size, ex_ea[1:0]);
                            mem_wdata    <= lane_wdata(ex_size, ex_dm_in);
                            req_size     <= ex_size;
                            req_unsigned <= ex_unsigned;
                            req_rd       <= ex_rd;
                            req_k        <= ex_ea[1:0];
                            timeout_cnt  <= '0;
                        end
                    end
                end

                REQ: begin
                    if (mem_ready) begin
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        wb_rd    <= req_rd;
                        if (!mem_we) begin
                            wb_en   <= (req_rd != 5'd0);
                            wb_data <= load_extract(req_size, req_k, req_unsigned, mem_rdata);
                        end
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        // Give up on the bus and retire as a bus error.
                        state    <= IDLE;
                        wb_valid <= 1'b1;
                        buserr   <= 1'b1;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a table of single-instruction vectors
// with hand-computed results, plus hand-written sequences for reset, timeout,
// back-to-back stalling and reset in the middle of a bus request.
module tb_mem_stage;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic        ex_load;
    logic        ex_store;
    logic [1:0]  ex_size;
    logic        ex_unsigned;
    logic [31:0] ex_ea;
    logic [31:0] ex_dm_in;
    logic [31:0] ex_alu_res;
    logic [4:0]  ex_rd;
    logic        ex_wb_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        wb_valid;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        adel;
    logic        ades;
    logic        buserr;

    int checks = 0;
    int errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ex_valid   (ex_valid),
        .ex_load    (ex_load),
        .ex_store   (ex_store),
        .ex_size    (ex_size),
        .ex_unsigned(ex_unsigned),
        .ex_ea      (ex_ea),
        .ex_dm_in   (ex_dm_in),
        .ex_alu_res (ex_alu_res),
        .ex_rd      (ex_rd),
        .ex_wb_en   (ex_wb_en),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .wb_valid   (wb_valid),
        .wb_en      (wb_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .adel       (adel),
        .ades       (ades),
        .buserr     (buserr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] ea;
        logic [31:0] dm;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        wen_in;
        logic        bus;          // a bus transaction is expected
        logic [3:0]  ready_after;  // REQ cycle (1-based) in which mem_ready is given
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_be;
        logic        chk_be;
        logic [31:0] e_wdata;
        logic        chk_wdata;
        logic        e_wb_en;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
        logic        chk_data;     // check wb_rd and wb_data
        logic        e_adel;
        logic        e_ades;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk_alu(input logic [31:0] alu, input logic [4:0] rd, input logic wen);
        vec_t v;
        v = '0;
        v.alu = alu; v.rd = rd; v.wen_in = wen;
        v.e_wb_en = wen; v.e_rd = rd; v.e_data = alu; v.chk_data = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk_load(input logic [1:0] size, input logic uns, input logic [31:0] ea,
                                     input logic [4:0] rd, input logic [3:0] ready_after,
                                     input logic [31:0] rdata, input logic [31:0] e_data);
        vec_t v;
        v = '0;
        v.ld = 1'b1; v.size = size; v.uns = uns; v.ea = ea; v.rd = rd; v.wen_in = 1'b1;
        v.bus = 1'b1; v.ready_after = ready_after; v.rdata = rdata;
        v.e_addr = {ea[31:2], 2'b00}; v.e_we = 1'b0;
        v.e_wb_en = (rd != 5'd0); v.e_rd = rd; v.e_data = e_data; v.chk_data = 1'b1;
        return v;
    endfunction

    function automatic vec_t mk_store(input logic both, input logic [1:0] size, input logic [31:0] ea,
                                      input logic [31:0] dm, input logic [3:0] ready_after,
                                      input logic [3:0] e_be, input logic [31:0] e_wdata);
        vec_t v;
        v = '0;
        v.ld = both; v.st = 1'b1; v.size = size; v.ea = ea; v.dm = dm; v.rd = 5'd9; v.wen_in = 1'b1;
        v.bus = 1'b1; v.ready_after = ready_after; v.rdata = 32'h5555_AAAA;
        v.e_addr = {ea[31:2], 2'b00}; v.e_we = 1'b1;
        v.e_be = e_be; v.chk_be = 1'b1; v.e_wdata = e_wdata; v.chk_wdata = 1'b1;
        v.e_wb_en = 1'b0;
        return v;
    endfunction

    function automatic vec_t mk_mis(input logic ld, input logic st, input logic [1:0] size,
                                    input logic [31:0] ea, input logic e_adel, input logic e_ades);
        vec_t v;
        v = '0;
        v.ld = ld; v.st = st; v.size = size; v.ea = ea; v.rd = 5'd3; v.wen_in = 1'b1;
        v.e_wb_en = 1'b0; v.e_adel = e_adel; v.e_ades = e_ades;
        return v;
    endfunction

    task automatic drive_idle_inputs();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'b00; ex_unsigned = 1'b0;
        ex_ea = '0; ex_dm_in = '0; ex_alu_res = '0; ex_rd = '0; ex_wb_en = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_size = v.size; ex_unsigned = v.uns;
        ex_ea = v.ea; ex_dm_in = v.dm; ex_alu_res = v.alu; ex_rd = v.rd; ex_wb_en = v.wen_in;
        step();
        ex_valid = 1'b0;
        if (v.bus) begin
            check({t, ".mem_req"}, mem_req, 1);
            check({t, ".stall"}, stall, 1);
            check({t, ".mem_we"}, mem_we, v.e_we);
            check({t, ".mem_addr"}, mem_addr, v.e_addr);
            if (v.chk_be) check({t, ".mem_be"}, mem_be, v.e_be);
            if (v.chk_wdata) check({t, ".mem_wdata"}, mem_wdata, v.e_wdata);
            for (int c = 1; c <= int'(v.ready_after); c++) begin
                mem_ready = (c == int'(v.ready_after));
                mem_rdata = mem_ready ? v.rdata : 32'hDEAD_0BAD;
                step();
            end
            mem_ready = 1'b0;
        end
        check({t, ".wb_valid"}, wb_valid, 1);
        check({t, ".wb_en"}, wb_en, v.e_wb_en);
        if (v.chk_data) begin
            check({t, ".wb_rd"}, wb_rd, v.e_rd);
            check({t, ".wb_data"}, wb_data, v.e_data);
        end
        check({t, ".adel"}, adel, v.e_adel);
        check({t, ".ades"}, ades, v.e_ades);
        check({t, ".buserr"}, buserr, 0);
        check({t, ".mem_req_after"}, mem_req, 0);
        check({t, ".stall_after"}, stall, 0);
        step();
        check({t, ".wb_valid_pulse"}, wb_valid, 0);
    endtask

    initial begin
        int cnt;

        rst = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        drive_idle_inputs();

        // Vector table: ALU passthrough, loads, stores, misaligned accesses.
        vecs[0]  = mk_alu(32'h1234_5678, 5'd5, 1'b1);
        vecs[1]  = mk_alu(32'hCAFE_F00D, 5'd7, 1'b0);
        vecs[2]  = mk_load(2'b00, 1'b0, 32'h0000_1001, 5'd8,  4'd3, 32'h11F0_2233, 32'hFFFF_FFF0);
        vecs[3]  = mk_load(2'b00, 1'b1, 32'h0000_1001, 5'd8,  4'd3, 32'h11F0_2233, 32'h0000_00F0);
        vecs[4]  = mk_store(1'b0, 2'b01, 32'h0000_2002, 32'hDEAD_BEEF, 4'd1, 4'b0011, 32'hBEEF_BEEF);
        vecs[5]  = mk_mis(1'b1, 1'b0, 2'b10, 32'h0000_0003, 1'b1, 1'b0);
        vecs[6]  = mk_mis(1'b0, 1'b1, 2'b01, 32'h0000_0001, 1'b0, 1'b1);
        vecs[7]  = mk_store(1'b0, 2'b00, 32'h0000_4003, 32'h0000_00A5, 4'd2, 4'b0001, 32'hA5A5_A5A5);
        vecs[8]  = mk_load(2'b01, 1'b0, 32'h0000_5000, 5'd10, 4'd2, 32'h8001_7FFF, 32'hFFFF_8001);
        vecs[9]  = mk_load(2'b01, 1'b1, 32'h0000_5002, 5'd11, 4'd1, 32'h8001_F00F, 32'h0000_F00F);
        vecs[10] = mk_load(2'b11, 1'b0, 32'h0000_6004, 5'd12, 4'd4, 32'hA1B2_C3D4, 32'hA1B2_C3D4);
        vecs[11] = mk_load(2'b00, 1'b0, 32'h0000_7000, 5'd0,  4'd1, 32'h7F00_0000, 32'h0000_007F);
        vecs[12] = mk_store(1'b0, 2'b10, 32'h0000_8008, 32'h0123_4567, 4'd3, 4'b1111, 32'h0123_4567);
        vecs[13] = mk_store(1'b1, 2'b00, 32'h0000_9001, 32'h0000_005A, 4'd1, 4'b0100, 32'h5A5A_5A5A);
        vecs[14] = mk_mis(1'b0, 1'b1, 2'b10, 32'h0000_0002, 1'b0, 1'b1);
        vecs[15] = mk_store(1'b0, 2'b00, 32'h0000_A000, 32'h0000_003C, 4'd1, 4'b1000, 32'h3C3C_3C3C);

        // Reset values.
        step();
        step();
        check("rst.mem_req", mem_req, 0);
        check("rst.mem_we", mem_we, 0);
        check("rst.stall", stall, 0);
        check("rst.wb_valid", wb_valid, 0);
        check("rst.wb_en", wb_en, 0);
        check("rst.flags", {29'b0, adel, ades, buserr}, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.mem_be", mem_be, 0);
        check("rst.mem_wdata", mem_wdata, 0);
        check("rst.wb_rd", wb_rd, 0);
        check("rst.wb_data", wb_data, 0);
        rst = 1'b0;

        // Idle with mem_ready pulsed outside REQ: nothing happens.
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ready = 1'b0;
        check("idle.wb_valid", wb_valid, 0);
        check("idle.mem_req", mem_req, 0);

        for (int i = 0; i < NVEC; i++) apply_vec(vecs[i], i);

        // Timeout with an ALU instruction held behind the stalled load.
        ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'b10; ex_ea = 32'h0000_B000; ex_rd = 5'd4;
        step();
        ex_load = 1'b0; ex_alu_res = 32'h0BAD_CAFE; ex_rd = 5'd6; ex_wb_en = 1'b1;
        cnt = 0;
        while (mem_req && cnt < 20) begin
            check("to.no_retire", wb_valid, 0);
            cnt++;
            step();
        end
        check("to.req_cycles", cnt, TIMEOUT);
        check("to.buserr", buserr, 1);
        check("to.wb_valid", wb_valid, 1);
        check("to.wb_en", wb_en, 0);
        check("to.stall", stall, 0);
        step();
        ex_valid = 1'b0;
        check("to.held.wb_valid", wb_valid, 1);
        check("to.held.wb_data", wb_data, 32'h0BAD_CAFE);
        check("to.held.wb_rd", wb_rd, 6);
        check("to.held.buserr", buserr, 0);
        step();

        // Back-to-back loads: the second is held until the first completes.
        ex_valid = 1'b1; ex_load = 1'b1; ex_size = 2'b10; ex_unsigned = 1'b0; ex_ea = 32'h0000_C000; ex_rd = 5'd13;
        step();
        ex_size = 2'b00; ex_ea = 32'h0000_D002; ex_rd = 5'd14;
        check("b2b.stall1", stall, 1);
        step();
        check("b2b.stall2", stall, 1);
        check("b2b.no_retire", wb_valid, 0);
        mem_ready = 1'b1; mem_rdata = 32'h1122_3344;
        step();
        mem_ready = 1'b0;
        check("b2b.first.stall", stall, 0);
        check("b2b.first.wb_valid", wb_valid, 1);
        check("b2b.first.wb_data", wb_data, 32'h1122_3344);
        check("b2b.first.wb_rd", wb_rd, 13);
        step();
        ex_valid = 1'b0; ex_load = 1'b0;
        check("b2b.second.mem_req", mem_req, 1);
        check("b2b.second.mem_addr", mem_addr, 32'h0000_D000);
        check("b2b.second.stall", stall, 1);
        mem_ready = 1'b1; mem_rdata = 32'h0000_8000;
        step();
        mem_ready = 1'b0;
        check("b2b.second.wb_valid", wb_valid, 1);
        check("b2b.second.wb_data", wb_data, 32'hFFFF_FF80);
        check("b2b.second.wb_rd", wb_rd, 14);
        step();

        // Reset in the middle of REQ abandons the access with no retire.
        ex_valid = 1'b1; ex_load = 1'b1; ex_size = 2'b10; ex_ea = 32'h0000_E000; ex_rd = 5'd15;
        step();
        drive_idle_inputs();
        check("mrst.mem_req_before", mem_req, 1);
        rst = 1'b1;
        step();
        check("mrst.mem_req", mem_req, 0);
        check("mrst.stall", stall, 0);
        check("mrst.wb_valid", wb_valid, 0);
        rst = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
        step();
        mem_ready = 1'b0;
        check("mrst.late.wb_valid", wb_valid, 0);
        check("mrst.late.mem_req", mem_req, 0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined MIPS core, between the execute stage and writeback. It consumes the execute results (ALU result, effective address, store data) and performs loads and stores on a single-outstanding request/ready data-memory bus. It handles big-endian byte-lane steering, sign and zero extension, misalignment and bus-timeout detection, and pipeline stall generation. Non-memory instructions pass through with one cycle of latency.

## Interface
- TIMEOUT_CYCLES, 255: number of REQ cycles without mem_ready before a bus error; legal range 1..1023.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  the execute stage presents an instruction.
- ex_load / ex_store  in  1 / 1  memory operation type; if both are set, the operation is a store.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
- ex_unsigned  in  1  selects zero extension (1) or sign extension (0) for loads.
- ex_ea  in  32  effective address.
- ex_dm_in  in  32  store data (rt value).
- ex_alu_res  in  32  result for non-memory instructions.
- ex_rd  in  5  destination register.
- ex_wb_en  in  1  instruction writes a register.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address: {ea[31:2], 2'b00}.
- mem_be  out  4  byte enables; bit 3 = bits [31:24].
- mem_wdata  out  32  write data, lane-replicated.
- mem_ready  in  1  bus completes the request in this cycle.
- mem_rdata  in  32  read data; valid when mem_ready=1.
- stall  out  1  upstream must hold ex_* inputs and not advance.
- wb_valid  out  1  one-cycle retire pulse.
- wb_en  out  1  write register wb_rd with wb_data.
- wb_rd  out  5  destination register.
- wb_data  out  32  writeback value.
- adel / ades / buserr  out  1 each  exception pulses (load misaligned, store misaligned, bus timeout), asserted with wb_valid.

## Operation
- States: IDLE and REQ. stall = (state == REQ), and it is registered; there is no combinational path from mem_ready to stall.
- In IDLE, with ex_valid=1, the instruction is accepted; it is consumed that cycle.
  - Non-memory instruction: the next cycle gives wb_valid=1, wb_data=ex_alu_res, wb_en=ex_wb_en.
  - Misaligned memory access (half with ea[0]=1; word with ea[1:0]≠0): no bus request. The next cycle gives wb_valid=1, wb_en=0, and adel=1 for a load or ades=1 for a store.
  - Aligned memory access: latch addr, be, wdata, we, size, unsigned, rd, ea[1:0]; go to REQ.
- In REQ: mem_req=1, and mem_addr/mem_be/mem_wdata/mem_we are stable. On mem_ready=1:
  - A load captures and extracts data.
  - The next cycle gives wb_valid=1; state returns to IDLE.
  - wb_en=1 for a load with rd≠0, and 0 for a store.
- Timeout counter: clears on entry to REQ and increments each REQ cycle. If it reaches TIMEOUT_CYCLES with mem_ready=0: drop mem_req the next cycle, go to IDLE, and pulse wb_valid=1, wb_en=0, buserr=1.
- Store byte enables (k = ea[1:0]):
  - byte: be = 1 << (3−k).
  - half: k=0 gives be=1100; k=2 gives be=0011.
  - word: be=1111.
- Store data is replicated: byte gives {4{dm_in[7:0]}}, half gives {2{dm_in[15:0]}}, word gives dm_in.
- Load extraction (big-endian):
  - byte lane k is rdata[31−8k −: 8].
  - half at k=0 is rdata[31:16]; at k=2 it is rdata[15:0].
  - The selected value is sign- or zero-extended to 32 bits according to ex_unsigned.
- ex_valid=0 in IDLE: wb_valid=0 the next cycle.
- ex_* inputs are ignored while in REQ.

## Timing
- Reset values: state=IDLE; mem_req, mem_we, stall, wb_valid, wb_en, adel, ades, buserr all 0; mem_addr, mem_be, mem_wdata, wb_rd, wb_data all 0.
- Reset during REQ: mem_req=0 the following cycle, and the in-flight access is abandoned with no retire pulse.
- Latency, non-memory or misaligned: accept in cycle N, wb_valid in N+1.
- Latency, memory access: accept in N; mem_req from N+1; mem_ready sampled in M≥N+1; wb_valid in M+1. Minimum is 2 cycles.
- Back-to-back: stall is 1 in cycles N+1..M and 0 in M+1. The held instruction is accepted in M+1.
- wb_valid, wb_en and exception flags are single-cycle pulses. wb_rd and wb_data hold their last value between pulses.
- mem_ready arriving outside REQ is ignored.

## Test plan
- ALU passthrough: ex_alu_res=0x1234_5678, rd=5, wb_en=1 → next cycle wb_valid=1, wb_data=0x12345678, wb_rd=5; mem_req never set.
- Signed byte load: ea=0x0000_1001, rdata=0x11_F0_22_33, ready after 3 REQ cycles → mem_addr=0x1000, be=1111 is not required for reads; wb_data=0xFFFF_FFF0 one cycle after ready. The same access with ex_unsigned=1 → 0x0000_00F0.
- Half store: ea=0x0000_2002, dm_in=0xDEAD_BEEF → mem_we=1, be=0011, wdata=0xBEEF_BEEF; wb_valid=1, wb_en=0 after ready.
- Misaligned word load: ea=0x3 → no mem_req; adel=1 and wb_valid=1 next cycle. Misaligned half store at ea=0x1 → ades=1.
- Timeout: TIMEOUT_CYCLES=4, mem_ready held at 0 → mem_req high exactly 4 cycles, then buserr=1 and wb_valid=1; stall drops; the next held instruction is accepted.
- Stall and reset: a second load is held while the first is in REQ → stall=1 until ready, then accepted. Asserting rst mid-REQ → mem_req=0 and stall=0 the next cycle, with no wb_valid.
